// File: rtl/i2c_pkg.sv
// Shared types and constants for the byte-level I2C target responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ACK     = 4'd1,
        S_WAIT_WR = 4'd2,
        S_READ    = 4'd3
    } state_t;

    // Active-low acknowledge as seen on the master's i_ACK input.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // LSB of the address byte; this target treats 1 as a write.
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/i2c_regfile.sv
// DEPTH x 8 register file: synchronous write, registered read, synchronous clear.
// Latency: write lands at the enabling edge; read data appears one edge after rd_en.
// Backpressure: none; rd_data holds its last value until the next rd_en.
module i2c_regfile #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [DEPTH];

    // Storage update, clear on reset, and the held read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            rd_data <= 8'h00;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/i2c_slave_responder.sv
// Byte-level I2C target: ACKs its address, writes/reads one byte through an auto-incrementing pointer.
// Latency: ACK low the cycle after the address edge, read data one cycle later, o_wr_done the cycle after data.
// Backpressure: none; bytes arriving in ACK/READ are dropped, a late write byte yields o_timeout.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         DEPTH      = 16,
    parameter int         PTR_W      = 4,
    parameter int         TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic [7:0]       i_SDA,
    input  logic             i_SDA_valid,
    output logic             o_ACK,
    output logic [7:0]       o_SDA,
    output logic             o_SDA_valid,
    output logic             o_wr_done,
    output logic             o_timeout,
    output logic [PTR_W-1:0] o_ptr,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic             rw_q, rw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             ack_d, sda_vld_d, wr_done_d, timeout_d;
    logic             wr_en, rd_en;

    // State, pointer, counter and every output strobe are registered here.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            rw_q        <= RW_READ;
            cnt_q       <= '0;
            ptr_q       <= '0;
            o_ACK       <= NACK;
            o_SDA_valid <= 1'b0;
            o_wr_done   <= 1'b0;
            o_timeout   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            o_ACK       <= ack_d;
            o_SDA_valid <= sda_vld_d;
            o_wr_done   <= wr_done_d;
            o_timeout   <= timeout_d;
            o_busy      <= (state_d != S_IDLE);
        end
    end

    // Next-state and next-output decode for the transaction FSM.
    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        ack_d     = NACK;
        sda_vld_d = 1'b0;
        wr_done_d = 1'b0;
        timeout_d = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_SDA_valid && (i_SDA[7:1] == SLAVE_ADDR)) begin
                    rw_d    = i_SDA[0];
                    ack_d   = ACK;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                cnt_d = '0;
                if (rw_q == RW_WRITE) begin
                    state_d = S_WAIT_WR;
                end else begin
                    // Launch the read on the way into READ so o_SDA is valid
                    // during the READ cycle itself, two cycles after the address.
                    rd_en     = 1'b1;
                    sda_vld_d = 1'b1;
                    ptr_d     = ptr_q + PTR_W'(1);
                    state_d   = S_READ;
                end
            end
            S_WAIT_WR: begin
                // A data byte on the final window cycle still wins over the timeout.
                if (i_SDA_valid) begin
                    wr_en     = 1'b1;
                    wr_done_d = 1'b1;
                    ptr_d     = ptr_q + PTR_W'(1);
                    state_d   = S_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_READ: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_ptr = ptr_q;

    i2c_regfile #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (i_rst),
        .wr_en   (wr_en),
        .wr_addr (ptr_q),
        .wr_data (i_SDA),
        .rd_en   (rd_en),
        .rd_addr (ptr_q),
        .rd_data (o_SDA)
    );

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Randomized bench for i2c_slave_responder with a transaction-level register-file model.
// Latency: expected events carry the exact cycle in which they must appear.
// Backpressure: none modelled; bytes during ACK/READ are random junk that must be ignored.
module tb_i2c_slave_responder;

    localparam int         DEPTH   = 16;
    localparam int         PTR_W   = 4;
    localparam int         TIMEOUT = 255;
    localparam logic [6:0] ADDR    = 7'h50;

    localparam int K_ACK = 0;
    localparam int K_RD  = 1;
    localparam int K_WR  = 2;
    localparam int K_TO  = 3;

    logic             clk = 1'b0;
    logic             i_rst;
    logic [7:0]       i_SDA;
    logic             i_SDA_valid;
    logic             o_ACK;
    logic [7:0]       o_SDA;
    logic             o_SDA_valid;
    logic             o_wr_done;
    logic             o_timeout;
    logic [PTR_W-1:0] o_ptr;
    logic             o_busy;

    i2c_slave_responder #(
        .SLAVE_ADDR (ADDR),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_SDA       (i_SDA),
        .i_SDA_valid (i_SDA_valid),
        .o_ACK       (o_ACK),
        .o_SDA       (o_SDA),
        .o_SDA_valid (o_SDA_valid),
        .o_wr_done   (o_wr_done),
        .o_timeout   (o_timeout),
        .o_ptr       (o_ptr),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    // Edge counter: the interval after edge e is cycle e.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] dat;
        int         ptr;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] mdl_mem [DEPTH];
    int         mdl_ptr = 0;
    int         errors  = 0;
    int         checks  = 0;
    bit         mon_en  = 1'b0;

    task automatic chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic void push(int kind, int c, logic [7:0] d, int p);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.dat  = d;
        e.ptr  = p;
        exp_q.push_back(e);
    endfunction

    task automatic observe(int kind, logic [7:0] dat);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected nothing", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
            errors++;
            $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                     kind, cyc, e.kind, e.cyc);
        end
        chk("event_ptr", int'(o_ptr), e.ptr);
        if (kind == K_RD) begin
            chk("read_data", int'(o_SDA), int'(e.dat));
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_ACK == 1'b0) observe(K_ACK, 8'h00);
            if (o_SDA_valid)   observe(K_RD, o_SDA);
            if (o_wr_done)     observe(K_WR, 8'h00);
            if (o_timeout) begin
                observe(K_TO, 8'h00);
                chk("busy_at_timeout", int'(o_busy), 0);
            end
        end
    end

    task automatic tick(bit v, logic [7:0] b);
        @(posedge clk);
        #1;
        i_SDA_valid = v;
        i_SDA       = b;
    endtask

    function automatic logic [7:0] rnd8();
        return 8'($urandom);
    endfunction

    // d = idle cycles in the write window before the data byte; d >= TIMEOUT means none.
    task automatic do_write(logic [7:0] data, int d, bit junk);
        int n;
        tick(1'b1, {ADDR, 1'b1});
        n = cyc + 1;
        push(K_ACK, n, 8'h00, mdl_ptr);
        tick(junk, rnd8());
        if (d >= TIMEOUT) begin
            push(K_TO, n + TIMEOUT + 1, 8'h00, mdl_ptr);
            repeat (TIMEOUT) tick(1'b0, rnd8());
        end else begin
            repeat (d) tick(1'b0, rnd8());
            tick(1'b1, data);
            mdl_mem[mdl_ptr] = data;
            mdl_ptr = (mdl_ptr + 1) % DEPTH;
            push(K_WR, n + 2 + d, 8'h00, mdl_ptr);
        end
    endtask

    task automatic do_read(bit junk1, bit junk2);
        int n;
        tick(1'b1, {ADDR, 1'b0});
        n = cyc + 1;
        push(K_ACK, n, 8'h00, mdl_ptr);
        push(K_RD, n + 1, mdl_mem[mdl_ptr], (mdl_ptr + 1) % DEPTH);
        mdl_ptr = (mdl_ptr + 1) % DEPTH;
        tick(junk1, rnd8());
        tick(junk2, rnd8());
    endtask

    task automatic do_mismatch(logic [7:0] b);
        logic [7:0] bb;
        bb = b;
        if (bb[7:1] == ADDR) bb[7:1] = bb[7:1] ^ 7'h01;
        tick(1'b1, bb);
        tick(1'b0, rnd8());
        chk("mismatch_busy", int'(o_busy), 0);
        chk("mismatch_ack", int'(o_ACK), 1);
        chk("mismatch_ptr", int'(o_ptr), mdl_ptr);
    endtask

    task automatic chk_reset_values(string tag);
        chk({tag, "_ack"}, int'(o_ACK), 1);
        chk({tag, "_sda"}, int'(o_SDA), 0);
        chk({tag, "_ptr"}, int'(o_ptr), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_strobes"}, int'({o_SDA_valid, o_wr_done, o_timeout}), 0);
    endtask

    initial begin
        int n;
        int sel;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
        i_rst       = 1'b1;
        i_SDA_valid = 1'b0;
        i_SDA       = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        i_rst  = 1'b0;
        mon_en = 1'b1;

        // Directed: write 3C, read back next entry, foreign address, timeout, boundary.
        do_write(8'h3C, 2, 1'b1);
        do_read(1'b1, 1'b1);
        chk("ptr_after_write_read", int'(o_ptr), 2);
        do_mismatch(8'h42);
        do_write(8'h77, TIMEOUT, 1'b0);
        tick(1'b0, 8'h00);
        chk("ptr_after_timeout", int'(o_ptr), mdl_ptr);
        do_write(8'h99, TIMEOUT - 1, 1'b0);

        // Fill every entry, then read one past the wrap.
        for (int i = 0; i < DEPTH; i++) do_write(8'(i), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        for (int i = 0; i <= DEPTH; i++) do_read(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Random mix of transactions.
        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4)       do_write(rnd8(), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            else if (sel < 7)  do_read(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (sel < 9)  do_mismatch(rnd8());
            else               do_write(rnd8(), TIMEOUT - int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat (int'($urandom_range(0, 2))) tick(1'b0, rnd8());
        end

        // Reset in the write window together with a data byte: nothing may commit.
        tick(1'b1, {ADDR, 1'b1});
        n = cyc + 1;
        push(K_ACK, n, 8'h00, mdl_ptr);
        tick(1'b0, rnd8());
        @(posedge clk);
        #1;
        i_rst       = 1'b1;
        i_SDA_valid = 1'b1;
        i_SDA       = 8'hEE;
        @(posedge clk);
        #1;
        i_rst       = 1'b0;
        i_SDA_valid = 1'b0;
        chk_reset_values("midreset");
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
        mdl_ptr = 0;
        do_read(1'b0, 1'b0);

        repeat (4) tick(1'b0, 8'h00);
        chk("pending_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
